// File: rtl/vend_pkg.sv
// Shared coin encoding, coin values and FSM state type for the vending payment front end.
package vend_pkg;

   typedef enum logic [1:0] {
      COIN_1  = 2'b00,
      COIN_2  = 2'b01,
      COIN_5  = 2'b10,
      COIN_10 = 2'b11
   } coin_t;

   localparam logic [3:0] COIN_VAL_1  = 4'd1;
   localparam logic [3:0] COIN_VAL_2  = 4'd2;
   localparam logic [3:0] COIN_VAL_5  = 4'd5;
   localparam logic [3:0] COIN_VAL_10 = 4'd10;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_REQUEST = 3'd2,
      S_WAIT    = 3'd3,
      S_PAYOUT  = 3'd4
   } state_t;

   function automatic logic [3:0] coin_value(input coin_t c);
      logic [3:0] v;
      case (c)
         COIN_1:  v = COIN_VAL_1;
         COIN_2:  v = COIN_VAL_2;
         COIN_5:  v = COIN_VAL_5;
         default: v = COIN_VAL_10;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/vend_coin_frontend_if.sv
// Request/response bus between the payment front end and the vending core.
interface vend_coin_frontend_if #(
   parameter int CREDIT_W = 4
);
   // req_valid is a one-cycle strobe with no back-pressure: the core must present
   // dispense/balance exactly RESP_LAT cycles later, valid for that single sampling edge.
   // deposited_amount/item_code stay stable from the strobe until the front end is idle again.
   logic                req_valid;
   logic [CREDIT_W-1:0] deposited_amount;
   logic [1:0]          item_code;
   logic                dispense;
   logic [CREDIT_W-1:0] balance;

   modport master (
      output req_valid,
      output deposited_amount,
      output item_code,
      input  dispense,
      input  balance
   );

   modport slave (
      input  req_valid,
      input  deposited_amount,
      input  item_code,
      output dispense,
      output balance
   );

endinterface

// File: rtl/vend_change_picker.sv
// Greedy change selection: largest coin (10, 5, 2, 1) not exceeding the remaining amount.
module vend_change_picker
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 4
) (
   input  logic [CREDIT_W-1:0] remaining,
   output coin_t               coin,
   output logic [CREDIT_W-1:0] value
);

   always_comb begin
      coin  = COIN_1;
      value = '0;
      if (remaining >= CREDIT_W'(COIN_VAL_10)) begin
         coin  = COIN_10;
         value = CREDIT_W'(COIN_VAL_10);
      end else if (remaining >= CREDIT_W'(COIN_VAL_5)) begin
         coin  = COIN_5;
         value = CREDIT_W'(COIN_VAL_5);
      end else if (remaining >= CREDIT_W'(COIN_VAL_2)) begin
         coin  = COIN_2;
         value = CREDIT_W'(COIN_VAL_2);
      end else if (remaining != '0) begin
         coin  = COIN_1;
         value = CREDIT_W'(COIN_VAL_1);
      end
   end

endmodule

// File: rtl/vend_coin_frontend.sv
// Vending payment front end: coin credit, item request to the core, greedy change payout.
// Optional idle auto-refund in COLLECT is built when VEND_TIMEOUT_EN is defined.
module vend_coin_frontend
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 4,
   parameter int RESP_LAT = 1
`ifdef VEND_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 1000
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 coin_valid,
   input  logic [1:0]           coin_type,
   output logic                 coin_accept,
   output logic                 coin_reject,
   input  logic                 sel_valid,
   input  logic [1:0]           sel_code,
   input  logic                 cancel,
   vend_coin_frontend_if.master core,
   output logic                 vend_done,
   output logic                 change_valid,
   output logic [1:0]           change_coin,
   output logic                 busy,
   output state_t               state_dbg
);

   localparam int WAIT_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

   state_t              state, state_nxt;
   logic [CREDIT_W-1:0] credit, credit_nxt;
   logic [CREDIT_W-1:0] payout, payout_nxt;
   logic [CREDIT_W-1:0] dep_q, dep_nxt;
   logic [1:0]          item_q, item_nxt;
   logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
   logic                accept_nxt, reject_nxt, done_nxt;
   logic [CREDIT_W:0]   coin_sum;
   logic                coin_fits;
   logic                tmo_hit;
   coin_t               pick_coin;
   logic [CREDIT_W-1:0] pick_value;

   // One extra bit so an overflowing coin is detected instead of wrapping the credit.
   assign coin_sum  = {1'b0, credit} + (CREDIT_W+1)'(coin_value(coin_t'(coin_type)));
   assign coin_fits = ~coin_sum[CREDIT_W];

   vend_change_picker #(
      .CREDIT_W (CREDIT_W)
   ) u_picker (
      .remaining (payout),
      .coin      (pick_coin),
      .value     (pick_value)
   );

`ifdef VEND_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [TMO_W-1:0] tmo_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmo_cnt <= '0;
      end else if ((state != S_COLLECT) || accept_nxt) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end

   assign tmo_hit = (state == S_COLLECT) && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         credit      <= '0;
         payout      <= '0;
         dep_q       <= '0;
         item_q      <= '0;
         wait_cnt    <= '0;
         coin_accept <= 1'b0;
         coin_reject <= 1'b0;
         vend_done   <= 1'b0;
      end else begin
         state       <= state_nxt;
         credit      <= credit_nxt;
         payout      <= payout_nxt;
         dep_q       <= dep_nxt;
         item_q      <= item_nxt;
         wait_cnt    <= wait_nxt;
         coin_accept <= accept_nxt;
         coin_reject <= reject_nxt;
         vend_done   <= done_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      credit_nxt = credit;
      payout_nxt = payout;
      dep_nxt    = dep_q;
      item_nxt   = item_q;
      wait_nxt   = wait_cnt;
      accept_nxt = 1'b0;
      reject_nxt = 1'b0;
      done_nxt   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (coin_valid) begin
               if (coin_fits) begin
                  accept_nxt = 1'b1;
                  credit_nxt = coin_sum[CREDIT_W-1:0];
                  state_nxt  = S_COLLECT;
               end else begin
                  reject_nxt = 1'b1;
               end
            end
         end
         S_COLLECT: begin
            // A refund (cancel or idle timeout) wins over a selection and bounces any coin.
            if (cancel || tmo_hit) begin
               reject_nxt = coin_valid;
               payout_nxt = credit;
               credit_nxt = '0;
               state_nxt  = S_PAYOUT;
            end else begin
               if (coin_valid) begin
                  if (coin_fits) begin
                     accept_nxt = 1'b1;
                     credit_nxt = coin_sum[CREDIT_W-1:0];
                  end else begin
                     reject_nxt = 1'b1;
                  end
               end
               if (sel_valid) begin
                  item_nxt  = sel_code;
                  dep_nxt   = credit_nxt;
                  wait_nxt  = '0;
                  state_nxt = S_REQUEST;
               end
            end
         end
         S_REQUEST: begin
            reject_nxt = coin_valid;
            wait_nxt   = '0;
            state_nxt  = S_WAIT;
         end
         S_WAIT: begin
            reject_nxt = coin_valid;
            if (wait_cnt == WAIT_W'(RESP_LAT - 1)) begin
               done_nxt   = core.dispense;
               credit_nxt = '0;
               if (core.balance == '0) begin
                  dep_nxt   = '0;
                  item_nxt  = '0;
                  state_nxt = S_IDLE;
               end else begin
                  payout_nxt = core.balance;
                  state_nxt  = S_PAYOUT;
               end
            end else begin
               wait_nxt = wait_cnt + WAIT_W'(1);
            end
         end
         S_PAYOUT: begin
            reject_nxt = coin_valid;
            payout_nxt = payout - pick_value;
            if (payout == pick_value) begin
               dep_nxt   = '0;
               item_nxt  = '0;
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign core.req_valid        = (state == S_REQUEST);
   assign core.deposited_amount = dep_q;
   assign core.item_code        = item_q;
   assign change_valid          = (state == S_PAYOUT);
   assign change_coin           = change_valid ? pick_coin : 2'b00;
   assign busy                  = (state != S_IDLE);
   assign state_dbg             = state;

endmodule

// File: tb/tb_vend_coin_frontend.sv
// Directed scoreboard bench for vend_coin_frontend; every output pulse is matched by cycle.
module tb_vend_coin_frontend;
   import vend_pkg::*;

   localparam int RESP_LAT = 1;
   localparam logic [1:0] C1 = 2'b00, C2 = 2'b01, C5 = 2'b10, C10 = 2'b11;
   localparam logic [2:0] EV_ACC = 3'd1, EV_REJ = 3'd2, EV_REQ = 3'd3, EV_DONE = 3'd4, EV_CHG = 3'd5;
   localparam int W = 25;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       coin_valid = 1'b0;
   logic [1:0] coin_type = 2'b00;
   logic       coin_accept, coin_reject;
   logic       sel_valid = 1'b0;
   logic [1:0] sel_code = 2'b00;
   logic       cancel = 1'b0;
   logic       vend_done, change_valid, busy;
   logic [1:0] change_coin;
   state_t     state_dbg;

   logic       core_disp = 1'b0;
   logic [3:0] core_bal = 4'd0;

   int cyc = 0;
   int t_now = 0;
   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   vend_coin_frontend_if #(.CREDIT_W(4)) core_if ();

   vend_coin_frontend #(
      .CREDIT_W (4),
      .RESP_LAT (RESP_LAT)
`ifdef VEND_TIMEOUT_EN
      ,
      .TIMEOUT_CYC (20)
`endif
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .coin_valid   (coin_valid),
      .coin_type    (coin_type),
      .coin_accept  (coin_accept),
      .coin_reject  (coin_reject),
      .sel_valid    (sel_valid),
      .sel_code     (sel_code),
      .cancel       (cancel),
      .core         (core_if),
      .vend_done    (vend_done),
      .change_valid (change_valid),
      .change_coin  (change_coin),
      .busy         (busy),
      .state_dbg    (state_dbg)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // core model: answers each request RESP_LAT cycles later for exactly one cycle
   initial begin
      core_if.dispense = 1'b0;
      core_if.balance  = 4'd0;
      forever begin
         @(negedge clk);
         if (core_if.req_valid) begin
            repeat (RESP_LAT) @(negedge clk);
            core_if.dispense = core_disp;
            core_if.balance  = core_bal;
            @(negedge clk);
            core_if.dispense = 1'b0;
            core_if.balance  = 4'd0;
         end
      end
   end

   function automatic void expect_ev(input int c, input logic [2:0] k, input logic [5:0] d);
      logic [15:0] cc;
      cc = c[15:0];
      exp_q.push_back({cc, k, d});
   endfunction

   task automatic got_ev(input logic [2:0] k, input logic [5:0] d);
      logic [W-1:0] act_w, exp_w;
      logic [15:0]  cc;
      cc = cyc[15:0];
      act_w = {cc, k, d};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event act cyc=%0d kind=%0d data=%h required none", cyc, k, d);
      end else begin
         exp_w = exp_q.pop_front();
         if (act_w !== exp_w) begin
            errors++;
            $display("FAIL event act cyc=%0d kind=%0d data=%h required cyc=%0d kind=%0d data=%h",
                     act_w[24:9], act_w[8:6], act_w[5:0], exp_w[24:9], exp_w[8:6], exp_w[5:0]);
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s act=%0h required=%0h", name, act, exp_v);
      end
   endtask

   // monitor: every output pulse must match the head of the expected queue
   initial begin
      forever begin
         @(negedge clk);
         if (coin_accept)       got_ev(EV_ACC, 6'd0);
         if (coin_reject)       got_ev(EV_REJ, 6'd0);
         if (core_if.req_valid) got_ev(EV_REQ, {core_if.item_code, core_if.deposited_amount});
         if (vend_done)         got_ev(EV_DONE, 6'd0);
         if (change_valid)      got_ev(EV_CHG, {4'd0, change_coin});
      end
   end

   // driver tasks: inputs change at negedge, DUT samples them at the next posedge
   task automatic step(input logic cv, input logic [1:0] ct, input logic sv, input logic [1:0] sc,
                       input logic cn);
      @(negedge clk);
      coin_valid = cv;
      coin_type  = ct;
      sel_valid  = sv;
      sel_code   = sc;
      cancel     = cn;
      t_now      = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({coin_accept, coin_reject, core_if.req_valid, core_if.deposited_amount,
                  core_if.item_code, vend_done, change_valid, change_coin, busy, state_dbg});
   endfunction

   initial begin
      int c;
      int n;
      // reset
      repeat (2) @(negedge clk);
      check("reset_outputs", all_outs(), 32'd0);
      reset = 1'b1;
      idle(2);

      // IDLE ignores selection and cancel
      step(1'b0, C1, 1'b1, 2'd3, 1'b1);
      idle(1);
      check("idle_ignore_busy", 32'(busy), 32'd0);

      // coin 5, select 00, core vends with zero balance; coin during REQUEST bounces
      core_disp = 1'b1; core_bal = 4'd0;
      step(1'b1, C5, 1'b0, 2'd0, 1'b0); expect_ev(t_now + 1, EV_ACC, 6'd0);
      step(1'b0, C1, 1'b1, 2'd0, 1'b0); c = t_now;
      expect_ev(c + 1, EV_REQ, {2'd0, 4'd5});
      step(1'b1, C1, 1'b0, 2'd0, 1'b0); expect_ev(c + 2, EV_REJ, 6'd0);
      expect_ev(c + 3, EV_DONE, 6'd0);
      idle(2);
      check("vend_back_idle", 32'(busy), 32'd0);
      check("vend_dep_cleared", 32'(core_if.deposited_amount), 32'd0);
      idle(2);

      // overflow: 10 + 5 = 15 fits, 2 and 1 bounce, credit presented is 15
      step(1'b1, C10, 1'b0, 2'd0, 1'b0); expect_ev(t_now + 1, EV_ACC, 6'd0);
      step(1'b1, C5,  1'b0, 2'd0, 1'b0); expect_ev(t_now + 1, EV_ACC, 6'd0);
      step(1'b1, C2,  1'b0, 2'd0, 1'b0); expect_ev(t_now + 1, EV_REJ, 6'd0);
      step(1'b1, C1,  1'b0, 2'd0, 1'b0); expect_ev(t_now + 1, EV_REJ, 6'd0);
      step(1'b0, C1,  1'b1, 2'd2, 1'b0); c = t_now;
      expect_ev(c + 1, EV_REQ, {2'd2, 4'd15});
      expect_ev(c + 3, EV_DONE, 6'd0);
      idle(5);

      // credit 8 then cancel (with a coin in the same cycle): change 5, 2, 1
      step(1'b1, C5, 1'b0, 2'd0, 1'b0); expect_ev(t_now + 1, EV_ACC, 6'd0);
      step(1'b1, C2, 1'b0, 2'd0, 1'b0); expect_ev(t_now + 1, EV_ACC, 6'd0);
      step(1'b1, C1, 1'b0, 2'd0, 1'b0); expect_ev(t_now + 1, EV_ACC, 6'd0);
      step(1'b1, C10, 1'b0, 2'd0, 1'b1); c = t_now;
      expect_ev(c + 1, EV_REJ, 6'd0);
      expect_ev(c + 1, EV_CHG, {4'd0, C5});
      expect_ev(c + 2, EV_CHG, {4'd0, C2});
      expect_ev(c + 3, EV_CHG, {4'd0, C1});
      idle(3);
      check("cancel_busy_last_coin", 32'(busy), 32'd1);
      idle(1);
      check("cancel_busy_after", 32'(busy), 32'd0);
      idle(2);

      // credit 7 (coin accepted with the selection), no dispense, balance 7: change 5, 2
      core_disp = 1'b0; core_bal = 4'd7;
      step(1'b1, C5, 1'b0, 2'd0, 1'b0); expect_ev(t_now + 1, EV_ACC, 6'd0);
      step(1'b1, C2, 1'b1, 2'd1, 1'b0); c = t_now;
      expect_ev(c + 1, EV_ACC, 6'd0);
      expect_ev(c + 1, EV_REQ, {2'd1, 4'd7});
      expect_ev(c + 3, EV_CHG, {4'd0, C5});
      expect_ev(c + 4, EV_CHG, {4'd0, C2});
      idle(3);
      check("nodisp_vend_done", 32'(vend_done), 32'd0);
      idle(2);
      check("nodisp_back_idle", 32'(busy), 32'd0);
      idle(2);

      // reset during the second payout cycle drops the rest of the change
      step(1'b1, C5, 1'b0, 2'd0, 1'b0); expect_ev(t_now + 1, EV_ACC, 6'd0);
      step(1'b1, C2, 1'b0, 2'd0, 1'b0); expect_ev(t_now + 1, EV_ACC, 6'd0);
      step(1'b1, C1, 1'b0, 2'd0, 1'b0); expect_ev(t_now + 1, EV_ACC, 6'd0);
      step(1'b0, C1, 1'b0, 2'd0, 1'b1); expect_ev(t_now + 1, EV_CHG, {4'd0, C5});
      idle(1);
      @(posedge clk);
      #1 reset = 1'b0;
      #1 check("midreset_outputs", all_outs(), 32'd0);
      idle(2);
      reset = 1'b1;
      idle(3);
      step(1'b1, C2, 1'b0, 2'd0, 1'b0); expect_ev(t_now + 1, EV_ACC, 6'd0);
      step(1'b0, C1, 1'b0, 2'd0, 1'b1); expect_ev(t_now + 1, EV_CHG, {4'd0, C2});
      idle(3);

`ifdef VEND_TIMEOUT_EN
      // idle timeout after 20 quiet cycles refunds credit 3 as 2, 1
      step(1'b1, C2, 1'b0, 2'd0, 1'b0); expect_ev(t_now + 1, EV_ACC, 6'd0);
      step(1'b1, C1, 1'b0, 2'd0, 1'b0); c = t_now;
      expect_ev(c + 1, EV_ACC, 6'd0);
      expect_ev(c + 21, EV_CHG, {4'd0, C2});
      expect_ev(c + 22, EV_CHG, {4'd0, C1});
      idle(25);
      check("timeout_back_idle", 32'(busy), 32'd0);
`endif

      // final report
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
